// File: rtl/mux_2_to_1_rr_arbiter.sv
// Round-robin arbiter that time-shares a registered 2:1 mux between two requesters.
// Each grant lasts at most HOLD_CYCLES cycles and ends early if its requester drops out.
module mux_2_to_1_rr_arbiter #(
    parameter int DATA_W      = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] M,
    output logic              valid,
    output logic              done,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t              r_state;
    state_t              w_nextState;
    state_t              w_choice;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_last;
    logic                r_sel;
    logic                r_done;
    logic                r_valid;
    logic [DATA_W-1:0]   r_m;
    logic [CNT_W-1:0]    r_cnt0;
    logic [CNT_W-1:0]    r_cnt1;
    logic                w_tenureEnd;
    logic                w_lastNext;
    logic                w_load;

    assign w_tenureEnd = ((r_state == GNT0) && ((r_hold == '0) || !req0)) ||
                         ((r_state == GNT1) && ((r_hold == '0) || !req1));

    // The pointer seen by Choose already reflects the tenure that ends on this edge.
    assign w_lastNext = w_tenureEnd ? (r_state == GNT1) : r_last;

    always_comb begin
        w_choice = IDLE;
        if (req0 && req1)
            w_choice = w_lastNext ? GNT0 : GNT1;
        else if (req0)
            w_choice = GNT0;
        else if (req1)
            w_choice = GNT1;
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        if ((r_state == IDLE) || w_tenureEnd) begin
            w_nextState = w_choice;
            w_load      = (w_choice != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_done  <= 1'b0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            r_state <= w_nextState;
            r_last  <= w_lastNext;
            r_done  <= w_tenureEnd;
            if (w_load) begin
                r_hold <= HOLD_W'(HOLD_CYCLES - 1);
                r_sel  <= (w_nextState == GNT1);
                if ((w_nextState == GNT0) && (r_cnt0 != '1))
                    r_cnt0 <= r_cnt0 + CNT_W'(1);
                if ((w_nextState == GNT1) && (r_cnt1 != '1))
                    r_cnt1 <= r_cnt1 + CNT_W'(1);
            end else if ((r_state != IDLE) && !w_tenureEnd) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    // Mux output lags the grant by one cycle; M is frozen while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_m     <= '0;
        end else begin
            r_valid <= (r_state != IDLE);
            if (r_state != IDLE)
                r_m <= r_sel ? d1 : d0;
        end
    end

    assign gnt0       = (r_state == GNT0);
    assign gnt1       = (r_state == GNT1);
    assign sel        = r_sel;
    assign M          = r_m;
    assign valid      = r_valid;
    assign done       = r_done;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_mux_2_to_1_rr_arbiter.sv
// Directed and randomized checks for the round-robin 2:1 mux arbiter, with a
// CNT_W=2 copy alongside for counter saturation.
module tb_mux_2_to_1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [2:0] d0 = 3'd0;
    logic [2:0] d1 = 3'd0;

    logic       gnt0, gnt1, sel, valid, done;
    logic [2:0] M;
    logic [7:0] grantCnt0, grantCnt1;

    logic       sGnt0, sGnt1, sSel, sValid, sDone;
    logic [2:0] sM;
    logic [1:0] sCnt0, sCnt1;

    int totalCount = 0;
    int badCount   = 0;
    bit randomPhase = 1'b0;

    mux_2_to_1_rr_arbiter #(.DATA_W(3), .HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .M(M), .valid(valid), .done(done),
        .grant_cnt0(grantCnt0), .grant_cnt1(grantCnt1)
    );

    mux_2_to_1_rr_arbiter #(.DATA_W(3), .HOLD_CYCLES(4), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(sGnt0), .gnt1(sGnt1), .sel(sSel), .M(sM), .valid(sValid), .done(sDone),
        .grant_cnt0(sCnt0), .grant_cnt1(sCnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural reference: 0=idle, 1=grant0, 2=grant1; stepped with blocking updates.
    int         mState = 0;
    int         mHold  = 0;
    bit         mLast  = 1'b1;
    bit         mSel   = 1'b0;
    bit         mValid = 1'b0;
    bit         mDone  = 1'b0;
    logic [2:0] mM     = 3'd0;
    int         mCnt0  = 0;
    int         mCnt1  = 0;

    function automatic int pick(bit r0, bit r1, bit lastServed);
        if (r0 && r1) return lastServed ? 1 : 2;
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mState = 0; mHold = 0; mLast = 1'b1; mSel = 1'b0;
            mValid = 1'b0; mDone = 1'b0; mM = 3'd0; mCnt0 = 0; mCnt1 = 0;
        end else begin
            int  prev;
            int  nxt;
            bit  start;
            prev   = mState;
            mValid = (prev != 0);
            if (prev != 0) mM = mSel ? d1 : d0;
            mDone = 1'b0;
            start = 1'b0;
            nxt   = prev;
            if (prev == 0) begin
                nxt   = pick(req0, req1, mLast);
                start = (nxt != 0);
            end else if (mHold == 0 || !((prev == 1) ? req0 : req1)) begin
                mDone = 1'b1;
                mLast = (prev == 2);
                nxt   = pick(req0, req1, mLast);
                start = (nxt != 0);
            end else begin
                mHold = mHold - 1;
            end
            if (start) begin
                mHold = 3;
                mSel  = (nxt == 2);
                if (nxt == 1 && mCnt0 < 255) mCnt0 = mCnt0 + 1;
                if (nxt == 2 && mCnt1 < 255) mCnt1 = mCnt1 + 1;
            end
            mState = nxt;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r0, input bit r1, input logic [2:0] a, input logic [2:0] b);
        req0 = r0;
        req1 = r1;
        d0   = a;
        d1   = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset gnt", {30'd0, gnt0, gnt1}, 32'd0);
        checkOutput("reset sel/valid/done", {29'd0, sel, valid, done}, 32'd0);
        checkOutput("reset M", {29'd0, M}, 32'd0);
        checkOutput("reset cnt", {16'd0, grantCnt0, grantCnt1}, 32'd0);

        // Single requester, 5 back-to-back tenures, then drop out.
        applyStimulus(1'b1, 1'b0, 3'b101, 3'b000);
        for (int e = 0; e <= 16; e++) begin
            tick();
            checkOutput("single gnt0", {31'd0, gnt0}, 32'd1);
            checkOutput("single done", {31'd0, done}, {31'd0, (e % 4 == 0) && (e != 0)});
            if (e >= 1) checkOutput("single M", {28'd0, valid, M}, {28'd0, 1'b1, 3'b101});
            else        checkOutput("single valid0", {31'd0, valid}, 32'd0);
            if (e % 4 == 0) begin
                checkOutput("single cnt0", {24'd0, grantCnt0}, 32'(e / 4 + 1));
                checkOutput("sat cnt0", {30'd0, sCnt0}, (e / 4 + 1 > 3) ? 32'd3 : 32'(e / 4 + 1));
                checkOutput("sat cnt1", {30'd0, sCnt1}, 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 3'b101, 3'b000);
        tick();
        checkOutput("drop idle", {29'd0, gnt0, gnt1, done}, 32'b001);
        tick();
        checkOutput("idle valid/done/sel", {29'd0, valid, done, sel}, 32'd0);
        checkOutput("idle M hold", {29'd0, M}, 32'b101);

        // Reset in the middle of a requester-1 tenure (hold=2).
        applyStimulus(1'b0, 1'b1, 3'b101, 3'b011);
        tick();
        checkOutput("pre-rst gnt1", {30'd0, gnt0, gnt1}, 32'b01);
        tick();
        checkOutput("pre-rst M", {28'd0, valid, M}, {28'd0, 1'b1, 3'b011});
        #3 rst = 1'b1;
        #1;
        checkOutput("async rst gnt/sel", {28'd0, gnt0, gnt1, sel, valid}, 32'd0);
        checkOutput("async rst M/done", {28'd0, done, M}, 32'd0);
        checkOutput("async rst cnt", {16'd0, grantCnt0, grantCnt1}, 32'd0);
        #1 applyStimulus(1'b1, 1'b1, 3'b101, 3'b010);
        #1 rst = 1'b0;

        // Contention: grants alternate with no idle gap.
        for (int e = 0; e <= 8; e++) begin
            tick();
            checkOutput("contend gnt", {30'd0, gnt0, gnt1},
                        (e >= 4 && e <= 7) ? 32'b01 : 32'b10);
            checkOutput("contend sel", {31'd0, sel}, {31'd0, (e >= 4 && e <= 7)});
            checkOutput("contend done", {31'd0, done}, {31'd0, (e == 4 || e == 8)});
            if (e == 0) checkOutput("contend M0", {28'd0, valid, M}, 32'd0);
            else        checkOutput("contend M", {28'd0, valid, M},
                                    {28'd0, 1'b1, (e <= 4) ? 3'b101 : 3'b010});
        end
        checkOutput("contend cnt", {16'd0, grantCnt0, grantCnt1}, {16'd0, 8'd2, 8'd1});

        // Early release of requester 1 with requester 0 idle.
        applyStimulus(1'b0, 1'b1, 3'b101, 3'b010);
        tick();
        checkOutput("switch gnt1", {28'd0, gnt0, gnt1, sel, done}, 32'b0111);
        checkOutput("switch cnt1", {24'd0, grantCnt1}, 32'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b101, 3'b010);
        tick();
        checkOutput("early done", {28'd0, gnt0, gnt1, done, valid}, 32'b0011);
        checkOutput("early M", {29'd0, M}, 32'b010);
        applyStimulus(1'b0, 1'b0, 3'b101, 3'b111);
        tick();
        checkOutput("early after", {28'd0, gnt1, done, valid, sel}, 32'b0001);
        checkOutput("early M hold", {29'd0, M}, 32'b010);

        // Randomized traffic against the reference model.
        randomPhase = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
            checkOutput("mutex", {31'd0, gnt0 & gnt1}, 32'd0);
            checkOutput("rand ctl", {27'd0, gnt0, gnt1, sel, valid, done},
                        {27'd0, mState == 1, mState == 2, mSel, mValid, mDone});
            checkOutput("rand sat ctl", {27'd0, sGnt0, sGnt1, sSel, sValid, sDone},
                        {27'd0, mState == 1, mState == 2, mSel, mValid, mDone});
            if (mValid) begin
                checkOutput("rand M", {29'd0, M}, {29'd0, mM});
                checkOutput("rand sat M", {29'd0, sM}, {29'd0, mM});
            end
            if (c % 64 == 63)
                checkOutput("rand cnt", {16'd0, grantCnt0, grantCnt1}, {16'd0, 8'(mCnt0), 8'(mCnt1)});
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
